// File: rtl/dbus_responder_pkg.sv
// Shared types for the dbus responder and its lane aligner.
// Console feature switch: DBUS_RESPONDER_CONSOLE_EN.
package dbus_responder_pkg;

  typedef enum logic [1:0] {
    DBUS_SIZE_BYTE    = 2'd0,
    DBUS_SIZE_HALF    = 2'd1,
    DBUS_SIZE_WORD    = 2'd2,
    DBUS_SIZE_ILLEGAL = 2'd3
  } dbus_size_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_HOLD
  } dbus_resp_state_t;

  // Console word sits this many words past the end of RAM.
  localparam int unsigned DBUS_CONSOLE_OFS_WORDS = 0;

endpackage

// File: rtl/dbus_lane_align.sv
// Byte-lane steering for dbus stores and sub-word load extension.
// Purely combinational; shared with the instruction-fetch port.
module dbus_lane_align
  import dbus_responder_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        unsign,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata_ext
);

  logic [31:0] shifted;

  always_comb begin
    shifted   = rword >> {lane, 3'b000};
    be        = '0;
    wdata_sh  = wdata;
    rdata_ext = '0;
    unique case (dbus_size_t'(size))
      DBUS_SIZE_BYTE: begin
        be        = 4'b0001 << lane;
        wdata_sh  = {4{wdata[7:0]}};
        rdata_ext = {{24{shifted[7] & ~unsign}},
                     shifted[7:0]};
      end
      DBUS_SIZE_HALF: begin
        be        = 4'b0011 << lane;
        wdata_sh  = {2{wdata[15:0]}};
        rdata_ext = {{16{shifted[15] & ~unsign}},
                     shifted[15:0]};
      end
      DBUS_SIZE_WORD: begin
        be        = 4'b1111;
        rdata_ext = shifted;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dbus_responder.sv
// Data-bus responder: word RAM, byte-lane stores, wait states, stall.
// Optional console port: DBUS_RESPONDER_CONSOLE_EN.
module dbus_responder
  import dbus_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic        re,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [1:0]  size,
  input  logic        unsign,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        fault,
  output logic        stall
);

  localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0] WAIT_INIT =
    (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  dbus_resp_state_t st, nxt;

  logic [3:0]    cnt;
  logic [IW+1:0] a_q;
  logic [1:0]    size_q;
  logic          uns_q, re_q, we_q, con_q, flt_q;
  logic [31:0]   wd_q;

  logic [31:0]   off;
  logic          in_ram, con_hit, aligned, legal;
  logic          idle, commit;

  logic [IW+1:0] c_a;
  logic [1:0]    c_size;
  logic          c_uns, c_re, c_we, c_con;
  logic [31:0]   c_wd;

  logic [3:0]    be;
  logic [31:0]   wsh, rext, rword;

  logic [31:0]   mem [DEPTH_WORDS];

  assign off    = addr - BASE_ADDR;
  assign in_ram = (addr >= BASE_ADDR)
               && ({1'b0, off} < RAM_BYTES);

`ifdef DBUS_RESPONDER_CONSOLE_EN
  localparam logic [32:0] CON_OFS =
    RAM_BYTES + 33'(4 * DBUS_CONSOLE_OFS_WORDS);
  assign con_hit = (addr >= BASE_ADDR)
                && ({1'b0, off} == CON_OFS);
`else
  assign con_hit = 1'b0;
`endif

  always_comb begin
    aligned = 1'b1;
    unique case (dbus_size_t'(size))
      DBUS_SIZE_HALF: aligned = ~addr[0];
      DBUS_SIZE_WORD: aligned = (addr[1:0] == 2'b00);
      default: ;
    endcase
  end

  assign legal = (re ^ we)
              && (size != DBUS_SIZE_ILLEGAL)
              && aligned
              && (in_ram || con_hit);

  // Zero-wait accesses commit straight from IDLE using live fields.
  assign idle   = (st == ST_IDLE);
  assign c_a    = idle ? off[IW+1:0] : a_q;
  assign c_size = idle ? size   : size_q;
  assign c_uns  = idle ? unsign : uns_q;
  assign c_re   = idle ? re     : re_q;
  assign c_we   = idle ? we     : we_q;
  assign c_con  = idle ? con_hit : con_q;
  assign c_wd   = idle ? wdata  : wd_q;

  assign rword = mem[c_a[IW+1:2]];

  dbus_lane_align u_align (
    .size      (c_size),
    .lane      (c_a[1:0]),
    .unsign    (c_uns),
    .wdata     (c_wd),
    .rword     (rword),
    .be        (be),
    .wdata_sh  (wsh),
    .rdata_ext (rext)
  );

  always_comb begin
    nxt    = st;
    commit = 1'b0;
    unique case (st)
      ST_IDLE: begin
        if (valid) begin
          if (!legal) begin
            nxt = ST_ACCESS;
          end else if (WAIT_CYCLES == 0) begin
            nxt    = ST_ACCESS;
            commit = 1'b1;
          end else begin
            nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt == 4'd0) begin
          nxt    = ST_ACCESS;
          commit = 1'b1;
        end
      end
      ST_ACCESS: nxt = ST_HOLD;
      ST_HOLD:   if (!valid) nxt = ST_IDLE;
      default:   nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st     <= ST_IDLE;
      cnt    <= '0;
      rdata  <= '0;
      a_q    <= '0;
      size_q <= '0;
      uns_q  <= 1'b0;
      re_q   <= 1'b0;
      we_q   <= 1'b0;
      con_q  <= 1'b0;
      flt_q  <= 1'b0;
      wd_q   <= '0;
    end else begin
      st <= nxt;
      if (idle && valid) begin
        a_q    <= off[IW+1:0];
        size_q <= size;
        uns_q  <= unsign;
        re_q   <= re;
        we_q   <= we;
        con_q  <= con_hit;
        wd_q   <= wdata;
        flt_q  <= ~legal;
        cnt    <= WAIT_INIT;
        if (!legal) rdata <= '0;
      end else if (st == ST_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (commit && c_re) rdata <= c_con ? '0 : rext;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && commit && c_we && !c_con) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[c_a[IW+1:2]][8*i +: 8] <= wsh[8*i +: 8];
      end
    end
  end

`ifdef DBUS_RESPONDER_CONSOLE_EN
  always_ff @(posedge clk) begin
    if (!rst && st == ST_ACCESS && !flt_q && con_q && we_q)
      $write("%c", wd_q[7:0]);
  end
`endif

  assign ready = (st == ST_ACCESS);
  assign fault = ready && flt_q;
  assign stall = (idle && valid) || (st == ST_WAIT);

endmodule

// File: tb/tb_dbus_responder.sv
// Randomized bench for dbus_responder against a byte-array model.
// Honours DBUS_RESPONDER_CONSOLE_EN for the console address.
module tb_dbus_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        valid = 1'b0;
  logic        re = 1'b0, we = 1'b0, unsign = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [1:0]  size = '0;

  logic        v1, v4;
  logic [31:0] rd1, rd4;
  logic        rdy1, rdy4, flt1, flt4, stl1, stl4;
  logic [31:0] rd_o;
  logic        rdy_o, flt_o, stl_o;

  int checks = 0;
  int failures = 0;

  logic [7:0]  mem_m [0:4095];
  logic [31:0] rd_m = '0;

  always #5 clk = ~clk;

  assign v1    = valid & ~sel;
  assign v4    = valid & sel;
  assign rd_o  = sel ? rd4 : rd1;
  assign rdy_o = sel ? rdy4 : rdy1;
  assign flt_o = sel ? flt4 : flt1;
  assign stl_o = sel ? stl4 : stl1;

  dbus_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .rst(rst), .valid(v1), .re(re), .we(we),
    .addr(addr), .size(size), .unsign(unsign), .wdata(wdata),
    .rdata(rd1), .ready(rdy1), .fault(flt1), .stall(stl1)
  );

  dbus_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(4)) u_w4 (
    .clk(clk), .rst(rst), .valid(v4), .re(re), .we(we),
    .addr(addr), .size(size), .unsign(unsign), .wdata(wdata),
    .rdata(rd4), .ready(rdy4), .fault(flt4), .stall(stl4)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit m_legal(bit r, bit w,
                                 logic [31:0] a, logic [1:0] s);
    bit al, inr;
    al  = (s == 2'd1) ? (a % 2 == 0)
        : (s == 2'd2) ? (a % 4 == 0) : 1'b1;
    inr = (a < 32'h1000);
`ifdef DBUS_RESPONDER_CONSOLE_EN
    if (a == 32'h1000) inr = 1'b1;
`endif
    return (r != w) && (s != 2'd3) && al && inr;
  endfunction

  // Drive one request, hold valid until ready, then idle two cycles.
  task automatic req(input bit r, input bit w,
                     input logic [31:0] a, input logic [1:0] s,
                     input bit u, input logic [31:0] d,
                     output logic [31:0] rd, output logic f,
                     output int lat, output int stalls);
    int n;
    @(negedge clk);
    re = r; we = w; addr = a; size = s;
    unsign = u; wdata = d; valid = 1'b1;
    #1;
    n = 0;
    stalls = 0;
    while (n < 40 && !rdy_o) begin
      if (stl_o) stalls++;
      @(negedge clk);
      n++;
    end
    if (!rdy_o) check("timeout", 32'd0, 32'd1);
    check("stall_at_ready", 32'(stl_o), 32'd0);
    lat = n;
    rd = rd_o;
    f = flt_o;
    valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Request on the WAIT_CYCLES=1 instance, checked against the model.
  task automatic op(input bit r, input bit w,
                    input logic [31:0] a, input logic [1:0] s,
                    input bit u, input logic [31:0] d,
                    output logic [31:0] got);
    bit lg;
    logic [31:0] v;
    logic f;
    int lat, stl, nb;
    lg = m_legal(r, w, a, s);
    nb = 1 << s;
    if (!lg) begin
      rd_m = '0;
    end else if (a >= 32'h1000) begin
      if (r) rd_m = '0;
    end else if (r) begin
      v = '0;
      for (int i = 0; i < nb; i++) v |= 32'(mem_m[a + i]) << (8 * i);
      if (nb == 1) v = u ? {24'd0, v[7:0]} : {{24{v[7]}}, v[7:0]};
      if (nb == 2) v = u ? {16'd0, v[15:0]} : {{16{v[15]}}, v[15:0]};
      rd_m = v;
    end else begin
      for (int i = 0; i < nb; i++) mem_m[a + i] = d[8*i +: 8];
    end
    sel = 1'b0;
    req(r, w, a, s, u, d, got, f, lat, stl);
    check("rdata", got, rd_m);
    check("fault", 32'(f), 32'(!lg));
    check("latency", 32'(lat), lg ? 32'd2 : 32'd1);
    check("stall_cycles", 32'(stl), lg ? 32'd2 : 32'd1);
  endtask

  initial begin
    logic [31:0] g, a;
    logic f;
    int lat, stl, rcnt, rpos, k;
    logic [1:0] s;

    repeat (3) @(negedge clk);
    check("rst_rdata", rd1, 32'd0);
    check("rst_ready", 32'(rdy1), 32'd0);
    check("rst_fault", 32'(flt1), 32'd0);
    check("rst_stall", 32'(stl1), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    op(0, 1, 32'h10, 2'd2, 0, 32'hDEADBEEF, g);
    op(1, 0, 32'h10, 2'd2, 0, 32'h0, g);
    check("word_rd", g, 32'hDEADBEEF);
    op(0, 1, 32'h13, 2'd0, 0, 32'h80, g);
    op(1, 0, 32'h13, 2'd0, 0, 32'h0, g);
    check("lb_signed", g, 32'hFFFFFF80);
    op(1, 0, 32'h13, 2'd0, 1, 32'h0, g);
    check("lb_unsigned", g, 32'h00000080);
    op(1, 0, 32'h10, 2'd2, 0, 32'h0, g);
    check("word_after_sb", g, 32'h80ADBEEF);
    op(1, 0, 32'h11, 2'd1, 0, 32'h0, g);
    check("misaligned_rd", g, 32'h0);
    op(1, 1, 32'h10, 2'd2, 0, 32'h0, g);
    op(1, 0, 32'h10, 2'd3, 0, 32'h0, g);
    op(0, 1, 32'h2000, 2'd2, 0, 32'h55, g);
    op(1, 0, 32'h10, 2'd2, 0, 32'h0, g);
    check("ram_unchanged", g, 32'h80ADBEEF);

    for (int i = 0; i < 16; i++) op(0, 1, 32'(i * 4), 2'd2, 0, $urandom, g);

    for (int i = 0; i < 60; i++) begin
      k = $urandom_range(0, 9);
      if (k < 7) begin
        s = 2'($urandom_range(0, 2));
        a = 32'($urandom_range(0, 63)) & ~((32'd1 << s) - 1);
        k = $urandom_range(0, 1);
        op(k == 1, k == 0, a, s, 1'($urandom), $urandom, g);
      end else begin
        s = 2'($urandom_range(0, 3));
        a = (k == 9) ? 32'h4000 + 32'($urandom_range(0, 15))
                     : 32'($urandom_range(0, 63));
        op(1'($urandom), 1'($urandom), a, s, 1'($urandom), $urandom, g);
      end
    end

    // WAIT_CYCLES=4 with valid held for ten cycles.
    sel = 1'b1;
    @(negedge clk);
    re = 0; we = 1; addr = 32'h40; size = 2'd2;
    unsign = 0; wdata = 32'h11223344; valid = 1'b1;
    #1;
    rcnt = 0;
    rpos = -1;
    for (int i = 0; i < 10; i++) begin
      if (rdy_o) begin
        rcnt++;
        rpos = i;
      end
      @(negedge clk);
    end
    valid = 1'b0;
    check("hold_ready_count", 32'(rcnt), 32'd1);
    check("hold_ready_pos", 32'(rpos), 32'd5);
    req(1, 0, 32'h40, 2'd2, 0, 32'h0, g, f, lat, stl);
    check("w4_rdata", g, 32'h11223344);
    check("w4_fault", 32'(f), 32'd0);
    check("w4_latency", 32'(lat), 32'd5);
    check("w4_stall", 32'(stl), 32'd5);
    req(1, 0, 32'h41, 2'd2, 0, 32'h0, g, f, lat, stl);
    check("w4_bad_fault", 32'(f), 32'd1);
    check("w4_bad_latency", 32'(lat), 32'd1);
    sel = 1'b0;

    // Reset during WAIT abandons the store.
    op(0, 1, 32'h20, 2'd2, 0, 32'h0, g);
    @(negedge clk);
    re = 0; we = 1; addr = 32'h20; size = 2'd2;
    unsign = 0; wdata = 32'h12345678; valid = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    valid = 1'b0;
    @(negedge clk);
    check("rst_mid_rdata", rd1, 32'd0);
    check("rst_mid_ready", 32'(rdy1), 32'd0);
    check("rst_mid_fault", 32'(flt1), 32'd0);
    check("rst_mid_stall", 32'(stl1), 32'd0);
    rst = 1'b0;
    rd_m = '0;
    repeat (2) @(negedge clk);
    op(1, 0, 32'h20, 2'd2, 0, 32'h0, g);
    check("rst_abandon", g, 32'h0);

    // One word past RAM: console when enabled, fault otherwise.
    op(0, 1, 32'h1000, 2'd0, 0, 32'h41, g);
    op(1, 0, 32'h1000, 2'd2, 0, 32'h0, g);
    op(1, 0, 32'h0, 2'd2, 0, 32'h0, g);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=%h exp=%h", 32'd0, 32'd1);
    $fatal(1);
  end

endmodule
